// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default parameters for the instruction-fetch sequencer.
// The state encoding is visible on fetch_state, so debug tools depend on it.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        STALL  = 2'd2,
        BUBBLE = 2'd3
    } fetch_state_t;

    localparam int DEF_BOOT_WAIT        = 2;
    localparam int DEF_REDIRECT_BUBBLES = 1;
    localparam int DEF_CNT_W            = 16;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bundle: pipeline requests in, mux selects, IF/ID control
// and perf counters out. The slave side is fetch_ctrl; the master side is the core.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             branch_taken;
    logic             jump_req;
    logic             stall_req;
    logic             md_busy;
    logic             PC_Select;
    logic             Jump_Sel;
    logic             pc_en;
    logic             ifid_flush;
    logic             ifid_valid;
    logic [1:0]       fetch_state;
    logic [CNT_W-1:0] redirect_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output branch_taken, jump_req, stall_req, md_busy,
        input  PC_Select, Jump_Sel, pc_en, ifid_flush, ifid_valid,
        input  fetch_state, redirect_cnt, stall_cnt
    );

    modport slave (
        input  branch_taken, jump_req, stall_req, md_busy,
        output PC_Select, Jump_Sel, pc_en, ifid_flush, ifid_valid,
        output fetch_state, redirect_cnt, stall_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping, so long runs read as "at least".
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: decides advance / hold / redirect each cycle and
// drives the PC muxes, PC enable and IF/ID control, plus redirect/stall counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int BOOT_WAIT        = DEF_BOOT_WAIT,
    parameter int REDIRECT_BUBBLES = DEF_REDIRECT_BUBBLES,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.slave  bus
);
    localparam logic [1:0] S_BOOT   = BOOT;
    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_STALL  = STALL;
    localparam logic [1:0] S_BUBBLE = BUBBLE;

    localparam int BCW = (BOOT_WAIT > 0) ? $clog2(BOOT_WAIT + 1) : 1;
    localparam int UCW = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;

    logic [1:0]     state_q, state_d;
    logic [BCW-1:0] boot_cnt_q, boot_cnt_d;
    logic [UCW-1:0] bubble_cnt_q, bubble_cnt_d;

    logic redirect, hold, redirect_acc;
    logic pc_sel_c, jump_sel_c, pc_en_c, flush_c;
    logic [CNT_W-1:0] redirect_cnt_w, stall_cnt_w;

    assign redirect = bus.branch_taken | bus.jump_req;
    assign hold     = bus.stall_req | bus.md_busy;

    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        pc_sel_c     = 1'b0;
        jump_sel_c   = 1'b0;
        pc_en_c      = 1'b0;
        flush_c      = 1'b0;
        redirect_acc = 1'b0;

        if (state_q == S_BOOT) begin
            flush_c = 1'b1;
            if (boot_cnt_q == '0) begin
                state_d = S_RUN;
            end else begin
                boot_cnt_d = boot_cnt_q - BCW'(1);
            end
        end else if (redirect) begin
            // Branch beats jump when both resolve together: it is the older instruction.
            pc_sel_c     = 1'b1;
            jump_sel_c   = bus.jump_req & ~bus.branch_taken;
            pc_en_c      = 1'b1;
            flush_c      = 1'b1;
            redirect_acc = 1'b1;
            if (REDIRECT_BUBBLES > 0) begin
                bubble_cnt_d = UCW'(REDIRECT_BUBBLES - 1);
                state_d      = S_BUBBLE;
            end else begin
                state_d = S_RUN;
            end
        end else if (hold) begin
            if (state_q != S_BUBBLE) begin
                state_d = S_STALL;
            end
        end else begin
            pc_en_c = 1'b1;
            if (state_q == S_BUBBLE) begin
                if (bubble_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    bubble_cnt_d = bubble_cnt_q - UCW'(1);
                end
            end else begin
                state_d = S_RUN;
            end
        end

        // Reset is asynchronous, so the outputs must go safe without waiting for an edge.
        if (reset) begin
            pc_sel_c   = 1'b0;
            jump_sel_c = 1'b0;
            pc_en_c    = 1'b0;
            flush_c    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_BOOT;
            boot_cnt_q   <= BCW'(BOOT_WAIT);
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_acc),
        .count (redirect_cnt_w)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (state_q == S_STALL),
        .count (stall_cnt_w)
    );

    assign bus.PC_Select    = pc_sel_c;
    assign bus.Jump_Sel     = jump_sel_c;
    assign bus.pc_en        = pc_en_c;
    assign bus.ifid_flush   = flush_c;
    assign bus.ifid_valid   = ~reset & ((state_q == S_RUN) | (state_q == S_STALL));
    assign bus.fetch_state  = state_q;
    assign bus.redirect_cnt = redirect_cnt_w;
    assign bus.stall_cnt    = stall_cnt_w;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: instance A uses defaults, instance B uses
// three redirect bubbles; both share clock and reset.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    fetch_ctrl_if #(.CNT_W(16)) a_if ();
    fetch_ctrl_if #(.CNT_W(16)) b_if ();

    fetch_ctrl #(.BOOT_WAIT(2), .REDIRECT_BUBBLES(1), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    fetch_ctrl #(.BOOT_WAIT(2), .REDIRECT_BUBBLES(3), .CNT_W(16)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        a_if.branch_taken = 1'b0; a_if.jump_req = 1'b0;
        a_if.stall_req    = 1'b0; a_if.md_busy  = 1'b0;
        b_if.branch_taken = 1'b0; b_if.jump_req = 1'b0;
        b_if.stall_req    = 1'b0; b_if.md_busy  = 1'b0;
        tick();
        tick();
        #1;
        check("rst_state", 32'(a_if.fetch_state), 32'd0);
        check("rst_flush", 32'(a_if.ifid_flush), 32'd1);
        check("rst_valid", 32'(a_if.ifid_valid), 32'd0);
        reset = 1'b0;

        // boot: three cycles frozen, then RUN
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("boot_state_%0d", i), 32'(a_if.fetch_state), 32'd0);
            check($sformatf("boot_pcen_%0d", i), 32'(a_if.pc_en), 32'd0);
            tick();
        end
        #1;
        check("run_state", 32'(a_if.fetch_state), 32'd1);
        check("run_pcen", 32'(a_if.pc_en), 32'd1);
        check("run_valid", 32'(a_if.ifid_valid), 32'd1);
        check("run_pcsel", 32'(a_if.PC_Select), 32'd0);

        // branch and jump together: branch wins
        a_if.branch_taken = 1'b1; a_if.jump_req = 1'b1;
        #1;
        check("bj_pcsel", 32'(a_if.PC_Select), 32'd1);
        check("bj_jsel", 32'(a_if.Jump_Sel), 32'd0);
        check("bj_flush", 32'(a_if.ifid_flush), 32'd1);
        tick();
        a_if.branch_taken = 1'b0; a_if.jump_req = 1'b0;
        #1;
        check("bj_bubble_state", 32'(a_if.fetch_state), 32'd3);
        check("bj_bubble_valid", 32'(a_if.ifid_valid), 32'd0);
        check("bj_bubble_pcen", 32'(a_if.pc_en), 32'd1);
        check("bj_redir_cnt", 32'(a_if.redirect_cnt), 32'd1);
        tick();
        #1;
        check("bj_after_state", 32'(a_if.fetch_state), 32'd1);
        check("bj_after_valid", 32'(a_if.ifid_valid), 32'd1);

        // stall for four cycles
        a_if.stall_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("stall_pcen_%0d", i), 32'(a_if.pc_en), 32'd0);
            check($sformatf("stall_valid_%0d", i), 32'(a_if.ifid_valid), 32'd1);
            tick();
        end
        a_if.stall_req = 1'b0;
        #1;
        check("stall_drop_state", 32'(a_if.fetch_state), 32'd2);
        check("stall_drop_pcen", 32'(a_if.pc_en), 32'd1);
        tick();
        #1;
        check("stall_cnt4", 32'(a_if.stall_cnt), 32'd4);
        check("stall_exit_state", 32'(a_if.fetch_state), 32'd1);

        // jump arriving during STALL overrides the stall
        a_if.stall_req = 1'b1;
        tick();
        a_if.jump_req = 1'b1;
        #1;
        check("sj_state", 32'(a_if.fetch_state), 32'd2);
        check("sj_pcsel", 32'(a_if.PC_Select), 32'd1);
        check("sj_jsel", 32'(a_if.Jump_Sel), 32'd1);
        check("sj_pcen", 32'(a_if.pc_en), 32'd1);
        check("sj_flush", 32'(a_if.ifid_flush), 32'd1);
        tick();
        a_if.jump_req = 1'b0; a_if.stall_req = 1'b0;
        #1;
        check("sj_next_state", 32'(a_if.fetch_state), 32'd3);
        check("sj_redir_cnt", 32'(a_if.redirect_cnt), 32'd2);
        check("sj_stall_cnt", 32'(a_if.stall_cnt), 32'd5);
        tick();

        // instance B: three bubbles, md_busy during two of them
        b_if.branch_taken = 1'b1;
        #1;
        check("b_redir_state", 32'(b_if.fetch_state), 32'd1);
        check("b_redir_pcsel", 32'(b_if.PC_Select), 32'd1);
        tick();
        b_if.branch_taken = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_if.md_busy = (i == 1 || i == 2);
            #1;
            check($sformatf("b_bub_state_%0d", i), 32'(b_if.fetch_state), 32'd3);
            check($sformatf("b_bub_pcen_%0d", i), 32'(b_if.pc_en), (i == 1 || i == 2) ? 32'd0 : 32'd1);
            check($sformatf("b_bub_valid_%0d", i), 32'(b_if.ifid_valid), 32'd0);
            tick();
        end
        b_if.md_busy = 1'b0;
        #1;
        check("b_run_state", 32'(b_if.fetch_state), 32'd1);
        check("b_redir_cnt", 32'(b_if.redirect_cnt), 32'd1);

        // asynchronous reset in the middle of a bubble
        a_if.branch_taken = 1'b1;
        #1;
        tick();
        #1;
        check("ar_pre_state", 32'(a_if.fetch_state), 32'd3);
        reset = 1'b1;
        #1;
        check("ar_state", 32'(a_if.fetch_state), 32'd0);
        check("ar_pcen", 32'(a_if.pc_en), 32'd0);
        check("ar_pcsel", 32'(a_if.PC_Select), 32'd0);
        check("ar_flush", 32'(a_if.ifid_flush), 32'd1);
        check("ar_valid", 32'(a_if.ifid_valid), 32'd0);
        check("ar_redir_cnt", 32'(a_if.redirect_cnt), 32'd0);
        check("ar_stall_cnt", 32'(a_if.stall_cnt), 32'd0);
        check("ar_b_redir_cnt", 32'(b_if.redirect_cnt), 32'd0);
        a_if.branch_taken = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_if.branch_taken = (i == 1);
            #1;
            check($sformatf("reboot_state_%0d", i), 32'(a_if.fetch_state), 32'd0);
            check($sformatf("reboot_pcen_%0d", i), 32'(a_if.pc_en), 32'd0);
            tick();
        end
        a_if.branch_taken = 1'b0;
        #1;
        check("reboot_run", 32'(a_if.fetch_state), 32'd1);
        check("reboot_redir_cnt", 32'(a_if.redirect_cnt), 32'd0);

        // hold a redirect continuously: one accepted per cycle until saturation
        a_if.branch_taken = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        #1;
        check("sat_cnt10", 32'(a_if.redirect_cnt), 32'd10);
        for (int i = 0; i < 65524; i++) tick();
        #1;
        check("sat_cnt65534", 32'(a_if.redirect_cnt), 32'd65534);
        for (int i = 0; i < 7; i++) tick();
        #1;
        check("sat_cnt_hold", 32'(a_if.redirect_cnt), 32'h0000FFFF);
        a_if.branch_taken = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
